// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch: FSM state encoding and default
// timing constants used by the control front-end, clock divider and
// display multiplexer.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_LAP   = 2'b11
  } sw_state_t;

  localparam int DEF_CLK_HZ          = 100_000_000;
  localparam int DEF_TICK_HZ         = 10;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;

  // The prescaler only advances while the stopwatch is counting.
  function automatic logic is_counting(input sw_state_t s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter and a
// registered one-cycle press pulse on the rising edge of the debounced level.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_level_q;
  logic          r_press;

  // Bring the raw asynchronous button into the clock domain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= '0;
    else          r_sync <= {r_sync[0], i_btn};
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive mismatching cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (r_sync[1] == r_level) begin
      r_cnt   <= '0;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt   <= '0;
      r_level <= r_sync[1];
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  // One-cycle press pulse on the rising edge of the debounced level; releases are silent.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_level_q <= 1'b0;
      r_press   <= 1'b0;
    end else begin
      r_level_q <= r_level;
      r_press   <= r_level & ~r_level_q;
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control front-end: debounced buttons drive a run/pause/lap FSM
// and a tick prescaler feeding the BCD counter (tick, clr) and display (hold).
// Optional feature macro: STOPWATCH_LAP_EN compiles in the lap button and LAP state.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ          = DEF_CLK_HZ,
  parameter int TICK_HZ         = DEF_TICK_HZ,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic       clk_100Mhz,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       btn_lap,
  output logic       tick,
  output logic       clr,
  output logic       running,
  output logic       hold,
  output logic [1:0] state
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  sw_state_t     r_state;
  sw_state_t     w_state_nxt;
  logic          w_clr_nxt;
  logic          w_start_ev;
  logic          w_clear_ev;
  logic          w_lap_ev;
  logic          w_cnt_en;
  logic [PW-1:0] r_pre;
  logic          r_tick;
  logic          r_clr;
  logic          r_running;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .i_clk(clk_100Mhz), .i_rst_n(reset), .i_btn(btn_start), .o_press(w_start_ev)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .i_clk(clk_100Mhz), .i_rst_n(reset), .i_btn(btn_clear), .o_press(w_clear_ev)
  );

`ifdef STOPWATCH_LAP_EN
  logic r_hold;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
    .i_clk(clk_100Mhz), .i_rst_n(reset), .i_btn(btn_lap), .o_press(w_lap_ev)
  );

  // Display is frozen exactly while in LAP.
  always_ff @(posedge clk_100Mhz or negedge reset) begin
    if (!reset) r_hold <= 1'b0;
    else        r_hold <= (w_state_nxt == ST_LAP);
  end

  assign hold = r_hold;
`else
  logic w_unused_lap;
  assign w_unused_lap = btn_lap;
  assign w_lap_ev     = 1'b0;
  assign hold         = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_100Mhz or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: only the highest-priority event (clear > start > lap) is
  // considered, so a clear in RUN/LAP swallows a simultaneous start or lap.
  always_comb begin
    w_state_nxt = r_state;
    w_clr_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_clear_ev)      w_clr_nxt   = 1'b1;
        else if (w_start_ev) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!w_clear_ev) begin
          if (w_start_ev)    w_state_nxt = ST_PAUSE;
          else if (w_lap_ev) w_state_nxt = ST_LAP;
        end
      end
      ST_PAUSE: begin
        if (w_clear_ev) begin
          w_state_nxt = ST_IDLE;
          w_clr_nxt   = 1'b1;
        end else if (w_start_ev) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_LAP: begin
        if (!w_clear_ev) begin
          if (w_start_ev)    w_state_nxt = ST_PAUSE;
          else if (w_lap_ev) w_state_nxt = ST_RUN;
        end
      end
    endcase
  end

  assign w_cnt_en = is_counting(r_state);

  // Prescaler: runs in RUN/LAP, holds in PAUSE to keep tick phase, zeroed with clr.
  always_ff @(posedge clk_100Mhz or negedge reset) begin
    if (!reset)         r_pre <= '0;
    else if (w_clr_nxt) r_pre <= '0;
    else if (w_cnt_en)  r_pre <= (r_pre == PRE_MAX) ? '0 : r_pre + 1'b1;
  end

  // Registered outputs; tick and clr come from disjoint states so never coincide.
  always_ff @(posedge clk_100Mhz or negedge reset) begin
    if (!reset) begin
      r_tick    <= 1'b0;
      r_clr     <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_tick    <= w_cnt_en && (r_pre == PRE_MAX);
      r_clr     <= w_clr_nxt;
      r_running <= is_counting(w_state_nxt);
    end
  end

  assign tick    = r_tick;
  assign clr     = r_clr;
  assign running = r_running;
  assign state   = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl (CLK_HZ=100, TICK_HZ=10, DEBOUNCE_CYCLES=4).
// A behavioural model tracks button history, debounced levels, mode and tick
// phase; a compare process checks every output on every falling clock edge.
module tb_stopwatch_ctrl;

  localparam int DIV = 10;
  localparam int DEB = 4;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_start = 1'b0, btn_clear = 1'b0, btn_lap = 1'b0;
  logic       tick, clr, running, hold;
  logic [1:0] state;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  stopwatch_ctrl #(.CLK_HZ(100), .TICK_HZ(10), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk_100Mhz(clk), .reset(rst_n), .btn_start(btn_start), .btn_clear(btn_clear),
    .btn_lap(btn_lap), .tick(tick), .clr(clr), .running(running), .hold(hold), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [1:0] hist[3];        // last two raw samples per button
  int         run_len[3];     // consecutive cycles synced level disagrees with accepted level
  bit         lvl[3];
  bit         p1[3], p2[3];   // press event travelling to the FSM
  bit         ev[3];
  int         m_state = 0;
  int         m_phase = 0;
  bit         e_tick = 0, e_clr = 0;

  initial begin
    for (int b = 0; b < 3; b++) begin
      hist[b] = '0; run_len[b] = 0; lvl[b] = 0; p1[b] = 0; p2[b] = 0; ev[b] = 0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int b = 0; b < 3; b++) begin
          hist[b] = '0; run_len[b] = 0; lvl[b] = 0; p1[b] = 0; p2[b] = 0;
        end
        m_state = 0; m_phase = 0; e_tick = 0; e_clr = 0;
      end else begin
        bit raw[3];
        bit s;
        int old;
        raw[0] = btn_start; raw[1] = btn_clear; raw[2] = btn_lap;
        for (int b = 0; b < 3; b++) begin
          ev[b] = p2[b]; p2[b] = p1[b]; p1[b] = 0;
          s = hist[b][1];
          hist[b] = {hist[b][0], raw[b]};
          if (s != lvl[b]) begin
            run_len[b]++;
            if (run_len[b] == DEB) begin
              lvl[b] = s; run_len[b] = 0; p1[b] = s;
            end
          end else begin
            run_len[b] = 0;
          end
        end
        ev[2] = ev[2] & LAP_EN;
        old = m_state;
        e_tick = ((old == 1) || (old == 3)) && (m_phase == DIV - 1);
        if ((old == 1) || (old == 3)) m_phase = (m_phase + 1) % DIV;
        e_clr = 0;
        if (ev[1]) begin
          if ((old == 0) || (old == 2)) begin m_state = 0; e_clr = 1; m_phase = 0; end
        end else if (ev[0]) begin
          m_state = (old == 0 || old == 2) ? 1 : 2;
        end else if (ev[2]) begin
          if (old == 1) m_state = 3;
          else if (old == 3) m_state = 1;
        end
      end
    end
  end

  // Compare process: every output against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("state", state, m_state);
        chk("tick", tick, e_tick);
        chk("clr", clr, e_clr);
        chk("running", running, (m_state == 1 || m_state == 3));
        chk("hold", hold, LAP_EN && (m_state == 3));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_state(input int exp, input int maxc, output int n);
    n = 0;
    while (state !== exp[1:0] && n <= maxc) begin step(1); n++; end
  endtask

  task automatic wait_tick(input int maxc, output int n);
    n = 0;
    do begin step(1); n++; end while (tick !== 1'b1 && n <= maxc);
  endtask

  task automatic count(input int n, output int ticks, output int clrs);
    ticks = 0; clrs = 0;
    repeat (n) begin step(1); ticks += tick; clrs += clr; end
  endtask

  task automatic press_start_to(input int exp, input string nm);
    int n;
    btn_start = 1'b1;
    wait_state(exp, 20, n);
    chk(nm, n, 8);
    btn_start = 1'b0;
    step(10);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t, c;
    rst_n = 1'b0;
    step(3);
    mon_en = 1'b1;
    rst_n = 1'b1;
    step(1);
    chk("reset_state", state, 0);
    chk("reset_outs", {tick, clr, running, hold}, 0);

    // Bounce rejection: toggle every 2 cycles for 20 cycles.
    for (int i = 0; i < 10; i++) begin btn_start = ~btn_start; step(2); end
    btn_start = 1'b0;
    count(10, t, c);
    chk("bounce_state", state, 0);
    chk("bounce_ticks", t, 0);

    // Clean start held high: RUN after 8 edges, then ticks every DIV.
    btn_start = 1'b1;
    wait_state(1, 20, n);
    chk("start_latency", n, 8);
    wait_tick(20, n);
    chk("first_tick", n, DIV);
    wait_tick(20, n);
    chk("tick_period", n, DIV);
    btn_start = 1'b0;
    step(12);
    chk("held_one_event", state, 1);

    // Pause with the prescaler at 6, then resume: next tick 4 cycles later.
    wait_tick(20, n);
    step(8);
    btn_start = 1'b1;
    wait_state(2, 20, n);
    chk("pause_latency", n, 8);
    btn_start = 1'b0;
    count(20, t, c);
    chk("pause_ticks", t, 0);
    btn_start = 1'b1;
    wait_state(1, 20, n);
    chk("resume_latency", n, 8);
    wait_tick(20, n);
    chk("resume_tick", n, 4);
    btn_start = 1'b0;
    step(10);

    // Clear while running is ignored.
    btn_clear = 1'b1;
    count(15, t, c);
    chk("clr_in_run", c, 0);
    chk("clr_in_run_state", state, 1);
    btn_clear = 1'b0;
    step(10);

    // Clear from PAUSE: one clr pulse in the first IDLE cycle.
    press_start_to(2, "pause2_latency");
    btn_clear = 1'b1;
    wait_state(0, 20, n);
    chk("clear_latency", n, 8);
    chk("clear_pulse", clr, 1);
    count(12, t, c);
    chk("clear_single", c, 0);
    btn_clear = 1'b0;
    step(10);

    // Lap in RUN, ticks continue, lap again back to RUN.
    press_start_to(1, "restart_latency");
    btn_lap = 1'b1;
    step(12);
    chk("lap_state", state, LAP_EN ? 3 : 1);
    chk("lap_hold", hold, LAP_EN);
    btn_lap = 1'b0;
    count(25, t, c);
    chk("lap_ticks_continue", (t >= 2), 1);
    btn_lap = 1'b1;
    step(12);
    chk("unlap_state", state, 1);
    chk("unlap_hold", hold, 0);
    btn_lap = 1'b0;
    step(10);

    // Simultaneous start+lap in RUN: start wins.
    btn_start = 1'b1; btn_lap = 1'b1;
    step(12);
    chk("start_lap_prio", state, 2);
    btn_start = 1'b0; btn_lap = 1'b0;
    step(10);

    // Asynchronous reset mid-run takes effect before the next edge.
    press_start_to(1, "run_again_latency");
    chk("pre_reset_running", running, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_outs", {tick, clr, running, hold}, 0);
    #2 rst_n = 1'b1;
    step(2);

    // Randomized button activity with occasional asynchronous resets.
    for (int i = 0; i < 300; i++) begin
      btn_start = ($urandom_range(0, 2) == 0);
      btn_clear = ($urandom_range(0, 4) == 0);
      btn_lap   = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 39) == 0) begin
        #1 rst_n = 1'b0;
        #3 rst_n = 1'b1;
      end
      step($urandom_range(1, 14));
    end
    btn_start = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
    step(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control front-end for the 3-digit BCD stopwatch, directly upstream of the unit/tens/hundreds counter. It debounces the raw start/stop, clear and lap pushbuttons. A run/pause/lap state machine turns the button events into a one-cycle count-enable tick at `TICK_HZ`, a one-cycle counter-clear pulse and a display-hold flag. The counter consumes `tick` and `clr`; the display multiplexer consumes `hold`.

## Interface
- `CLK_HZ`, 100_000_000, input clock frequency
- `TICK_HZ`, 10, count-tick rate; `DIV = CLK_HZ/TICK_HZ`, must be ≥ 2
- `DEBOUNCE_CYCLES`, 1_000_000, consecutive stable cycles required to accept a level change (10 ms)

Ports:
- `clk_100Mhz` input 1: the single clock.
- `reset` input 1: asynchronous, active-low.
- `btn_start` input 1: raw start/stop button, active-high, asynchronous.
- `btn_clear` input 1: raw clear button, active-high, asynchronous.
- `btn_lap` input 1: raw lap button, active-high, asynchronous.
- `tick` output 1: one-cycle count enable for the BCD counter.
- `clr` output 1: one-cycle synchronous clear for the BCD counter.
- `running` output 1: high in RUN and LAP.
- `hold` output 1: display freeze, high in LAP only.
- `state` output 2: current FSM state.

## Operation
- **Per-button debounce**
  - Input passes through a 2-flop synchronizer, then a stability counter.
  - When the synchronized level differs from the debounced level for `DEBOUNCE_CYCLES` consecutive cycles, the debounced level updates.
  - Any mismatch-free cycle (synchronized level equals debounced level) resets the counter.
  - A press event is a one-cycle pulse on the rising edge of the debounced level. Releases produce no event.
- **Event priority within a cycle:** clear > start > lap. Only the highest-priority event is acted on; the others are dropped.
- **FSM states:** IDLE=00, RUN=01, PAUSE=10, LAP=11.
  - IDLE: start→RUN. clear→IDLE, pulses `clr`. lap is ignored.
  - RUN: start→PAUSE. lap→LAP. clear is ignored.
  - PAUSE: start→RUN. clear→IDLE, pulses `clr`. lap is ignored.
  - LAP: lap→RUN. start→PAUSE. clear is ignored.
- **Prescaler**
  - Counter of width `$clog2(DIV)`, advancing only in RUN and LAP.
  - When it reaches `DIV-1` it wraps to 0 and `tick` pulses.
  - It holds its value in PAUSE, so pausing preserves the tick phase.
  - It is zeroed on any `clr` pulse.
- **Hold and counting:** ticks continue during LAP, so the counter keeps counting while the display is frozen.
- **Output ranges:** `tick` and `clr` are never high in the same cycle. `clr` never occurs in RUN or LAP.

## Timing
- **Reset (asynchronous, `reset`=0):**
  - `state`=IDLE.
  - `tick`, `clr`, `running`, `hold` are 0.
  - Prescaler, debounce counters and synchronizers are 0.
  - Effect is immediate, including mid-count or mid-debounce.
  - The first edge after deassertion is treated normally.
- **All outputs are registered.**
- **Press latency:** raw rising edge to press event is 2 (sync) + `DEBOUNCE_CYCLES` + 1 cycles. The state and outputs update on the edge following the event.
- **`clr` timing:** asserted for exactly the one cycle in which `state` first reads IDLE after the transition.
- **First tick after entering RUN from IDLE:** `DIV` cycles after `state` becomes RUN.
- **`tick` period:** exactly `DIV` cycles in steady RUN/LAP.
- **Held button:** produces one event only; no auto-repeat.

## Configuration
- `STOPWATCH_LAP_EN` defined:
  - lap debouncer and LAP state are compiled in;
  - behaviour is as above.
- `STOPWATCH_LAP_EN` undefined:
  - `btn_lap` is unconnected internally;
  - LAP is unreachable;
  - `hold` is tied 0;
  - the lap debouncer is not instantiated;
  - all other behaviour is identical.

## Structure
- **Shared package `stopwatch_pkg`:**
  - 2-bit state encoding constants (IDLE, RUN, PAUSE, LAP).
  - Default `CLK_HZ`, `TICK_HZ` and `DEBOUNCE_CYCLES` constants, shared with the clock divider and display multiplexer.
- **Sub-module `btn_debounce`:**
  - Contains the synchronizer, stability counter and rising-edge pulse.
  - Parameterised by `DEBOUNCE_CYCLES`.
  - Instantiated once per button (two or three times).
- **FSM and prescaler:** live in `stopwatch_ctrl`.

## Test plan
Bench parameters: `CLK_HZ`=100, `TICK_HZ`=10 (`DIV`=10), `DEBOUNCE_CYCLES`=4.
- **Bounce rejection:** toggle `btn_start` every 2 cycles for 20 cycles, then release → no event; `state` stays 00, no `tick`.
- **Clean start:** hold `btn_start` high → `state`=01 at cycle 2+4+1+1 = 8; first `tick` 10 cycles later; then one `tick` every 10 cycles.
- **Pause and resume:** pause with the prescaler at 6 → no ticks in PAUSE, prescaler frozen at 6. Resume → next `tick` 4 cycles after `state`=01.
- **Clear:** clear in PAUSE → `state`=00 and `clr`=1 for exactly one cycle, prescaler 0. Clear in RUN → ignored, no `clr`.
- **Lap:** lap in RUN → `state`=11, `hold`=1, ticks continue. Lap again → `state`=01, `hold`=0. Simultaneous start+lap events in RUN → PAUSE only.
- **Reset mid-run:** drive `reset`=0 mid-run, asynchronously between edges → all outputs 0 and `state`=00 before the next clock edge. Repeat the lap case with `STOPWATCH_LAP_EN` undefined → `hold` stays 0, `state` never 11.
